vdp_text_engine: RTL and testbench
==================================

// Module: vdp_text_engine
// PURPOSE
// Parametrised text-mode VDP core: COLS x ROWS character grid with per-cell fg/bg colour attribute,
// integer pixel scaling, buffered CPU write port and vblank NMI. Sits between the hvsync_generator
// (timing in) and the VGA pins; external ascii_array glyph ROM is looked up through glyph_* ports.
// CPU writes are queued in a FIFO and committed to single-port VRAM only during blanking.
// PARAMETERS
// COLS         40   characters per row
// ROWS         30   character rows; CELLS = COLS*ROWS, AW = clog2(CELLS) (localparams)
// SCALE_LOG2   1    pixel replication 2**SCALE_LOG2; cell = 8<<SCALE_LOG2 px square
// HV_W         10   width of hpos/vpos
// FIFO_DEPTH   8    write FIFO entries (power of 2, >=2)
// VBLANK_LINE  482  vpos at which vblank flag sets
// PORTS
// clk          in   1     pixel clock
// reset        in   1     synchronous, active-high
// hpos, vpos   in   HV_W  beam position from timing generator
// display_on   in   1     active video
// hsync_in     in   1     from timing generator
// vsync_in     in   1     from timing generator
// cpu_we       in   1     one-clk write strobe, clk domain
// cpu_addr     in   2     0=char data, 1=attribute, 2=control, 3=address byte
// cpu_data     in   8     write data
// status       out  8     {vblank,fifo_full,overflow,fifo_empty,4'b0}
// glyph_code   out  8     char code to glyph ROM
// glyph_row    out  3     glyph scanline
// glyph_bits   in   8     glyph row, combinational same cycle, MSB = leftmost pixel
// hsync, vsync out  1     sync delayed to match rgb
// nmi          out  1     active-low interrupt
// rgb          out  3     {b,g,r}
// BEHAVIOUR
// Reset: ctrl=0, attr=6'b000_111 (bg=0,fg=7), ptr=0, addr toggle=low, FIFO flushed, overflow=0,
//  vblank=0, nmi=1, rgb=0, hsync/vsync pipeline=0. VRAM contents not cleared.
// Write decode (cpu_we high): addr0 -> enqueue {ptr,cpu_data,attr}, ptr=(ptr==CELLS-1)?0:ptr+1;
//  addr1 -> attr={bg=data[5:3],fg=data[2:0]}; addr2 -> ctrl=data (b7 display en, b6 irq en,
//  b5 cursor en), clears vblank, overflow, toggle; addr3 -> toggle low: lo byte latched;
//  toggle high: ptr={data,lo}, loaded as 0 if >=CELLS. Toggle flips each addr3 write.
// FIFO full on addr0 write: entry dropped, ptr still advances, overflow sticky set.
// Drain: when !display_on and FIFO non-empty, one entry written to VRAM per clk; never during active video.
// Enqueue and drain same clk: both occur, occupancy unchanged.
// Render pipeline, fixed 2-clk latency: T0 cell=(vpos>>(3+S))*COLS+(hpos>>(3+S)) read from VRAM;
//  T1 glyph_code=char, glyph_row=vpos[S+2:S] (delayed), bit=glyph_bits[7-hpos[S+2:S] delayed];
//  T2 rgb registered. hsync/vsync delayed by 2 clks identically.
// rgb = (display_on_d2 && ctrl[7] && cell in grid) ? (bit?fg:bg) : 0; outside grid -> 0.
// vblank sets on first clk vpos==VBLANK_LINE; clears at vpos==0 or control write.
// nmi = ~(vblank && ctrl[6]), registered.
// CONFIGURATION
// CURSOR_EN defined: cell at ptr rendered with fg/bg swapped when ctrl[5] and frame_ctr[4]
//  (6-bit frame counter, increments at vblank set, reset 0). Undefined: ctrl[5] ignored, no counter.
// TESTING
// Reset, ctrl=8'h80, write 'A' at ptr 0 -> VRAM[0]=41/attr 07; rgb 7/0 per glyph, 2 clks after hpos.
// Set addr 1199 (lo 8'hAF, hi 8'h04), 2 data writes -> cells 1199 and 0 written, ptr=1.
// 9 data writes during active video, depth 8 -> status fifo_full=1, overflow=1; 8 entries drained in blanking.
// ctrl=8'hC0, run to vpos=482 -> nmi low next clk; write ctrl -> nmi high.
// Addr write 0xFFFF -> ptr=0; reset mid-drain -> FIFO empty, status=8'h10.
// CURSOR_EN: ctrl=8'hA0 -> cell at ptr swaps fg/bg on frames with frame_ctr[4]=1 only.

Source files
------------

// File: rtl/vdp_text_engine.sv
// Text-mode VDP core: COLS x ROWS character grid, FIFO-buffered CPU writes committed to VRAM in blanking.
// Render latency is a fixed 2 clks; define CURSOR_EN to enable the blinking cursor at the write pointer.
module vdp_text_engine #(
  parameter int COLS        = 40,
  parameter int ROWS        = 30,
  parameter int SCALE_LOG2  = 1,
  parameter int HV_W        = 10,
  parameter int FIFO_DEPTH  = 8,
  parameter int VBLANK_LINE = 482
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [HV_W-1:0] hpos,
  input  logic [HV_W-1:0] vpos,
  input  logic            display_on,
  input  logic            hsync_in,
  input  logic            vsync_in,
  input  logic            cpu_we,
  input  logic [1:0]      cpu_addr,
  input  logic [7:0]      cpu_data,
  output logic [7:0]      status,
  output logic [7:0]      glyph_code,
  output logic [2:0]      glyph_row,
  input  logic [7:0]      glyph_bits,
  output logic            hsync,
  output logic            vsync,
  output logic            nmi,
  output logic [2:0]      rgb
);
  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);
  localparam int FW    = $clog2(FIFO_DEPTH);
  localparam int S     = SCALE_LOG2;
  localparam int EW    = AW + 14;
  localparam logic [HV_W-1:0] VBL      = HV_W'(VBLANK_LINE);
  localparam logic [HV_W-1:0] COLS_V   = HV_W'(COLS);
  localparam logic [HV_W-1:0] ROWS_V   = HV_W'(ROWS);
  localparam logic [AW-1:0]   LAST     = AW'(CELLS - 1);
  localparam logic [15:0]     CELLS_16 = 16'(CELLS);

  logic [7:0]    r_ctrl;
  logic [5:0]    r_attr;
  logic [AW-1:0] r_ptr;
  logic          r_tog;
  logic [7:0]    r_lo;
  logic          r_ovf;
  logic          r_vblank;
  logic          r_nmi;
  logic [2:0]    r_rgb;
  logic [1:0]    r_hs;
  logic [1:0]    r_vs;
  logic [FW:0]   r_wp;
  logic [FW:0]   r_rp;
  logic [EW-1:0] r_fifo [FIFO_DEPTH];
  logic [13:0]   r_vram [CELLS];
  logic [13:0]   r_cell;
  logic [HV_W-1:0] r_vpos_d1;
  logic [2:0]    r_hsub_d1;
  logic          r_don_d1;
  logic          r_grid_d1;

  logic [HV_W-1:0] w_col;
  logic [HV_W-1:0] w_row;
  logic            w_in_grid;
  logic [AW-1:0]   w_cell;
  logic            w_empty;
  logic            w_full;
  logic            w_wr_data;
  logic            w_wr_attr;
  logic            w_wr_ctrl;
  logic            w_wr_addr;
  logic            w_enq;
  logic            w_drain;
  logic [EW-1:0]   w_head;
  logic [15:0]     w_newptr;
  logic            w_vb_rise;
  logic            w_vb_nxt;
  logic [7:0]      w_ctrl_nxt;
  logic            w_bit;
  logic            w_swap;
  logic [2:0]      w_pix;
  logic            w_unused;

  assign w_col     = hpos >> (3 + S);
  assign w_row     = vpos >> (3 + S);
  assign w_in_grid = (w_col < COLS_V) && (w_row < ROWS_V);
  assign w_cell    = w_in_grid ? AW'(32'(w_row) * COLS + 32'(w_col)) : '0;

  assign w_empty   = (r_wp == r_rp);
  assign w_full    = (r_wp[FW] != r_rp[FW]) && (r_wp[FW-1:0] == r_rp[FW-1:0]);
  assign w_wr_data = cpu_we && (cpu_addr == 2'd0);
  assign w_wr_attr = cpu_we && (cpu_addr == 2'd1);
  assign w_wr_ctrl = cpu_we && (cpu_addr == 2'd2);
  assign w_wr_addr = cpu_we && (cpu_addr == 2'd3);
  assign w_enq     = w_wr_data && !w_full;
  assign w_drain   = !display_on && !w_empty;
  assign w_head    = r_fifo[r_rp[FW-1:0]];
  assign w_newptr  = {cpu_data, r_lo};

  // vblank sets only on the first clk of the line so a control write can clear it mid-line
  assign w_vb_rise  = (vpos == VBL) && (r_vpos_d1 != VBL);
  assign w_ctrl_nxt = w_wr_ctrl ? cpu_data : r_ctrl;
  always_comb begin
    w_vb_nxt = r_vblank;
    if (w_vb_rise) w_vb_nxt = 1'b1;
    if (vpos == '0 || w_wr_ctrl) w_vb_nxt = 1'b0;
  end

`ifdef CURSOR_EN
  logic [5:0] r_frame;
  logic       r_cur_d1;
  assign w_swap = r_cur_d1 && r_ctrl[5] && r_frame[4];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame  <= '0;
      r_cur_d1 <= 1'b0;
    end else begin
      if (w_vb_rise) r_frame <= r_frame + 1'b1;
      r_cur_d1 <= w_in_grid && (w_cell == r_ptr);
    end
  end
`else
  assign w_swap = 1'b0;
`endif

  // swapping fg/bg is the same as inverting the glyph bit
  assign w_bit = glyph_bits[3'd7 - r_hsub_d1];
  assign w_pix = (w_bit ^ w_swap) ? r_cell[2:0] : r_cell[5:3];

  // single VRAM port: drain writes in blanking, render reads otherwise
  always_ff @(posedge clk) begin
    if (w_drain) r_vram[w_head[EW-1:14]] <= w_head[13:0];
    else         r_cell <= r_vram[w_cell];
    if (w_enq)   r_fifo[r_wp[FW-1:0]] <= {r_ptr, cpu_data, r_attr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl    <= '0;
      r_attr    <= 6'b000_111;
      r_ptr     <= '0;
      r_tog     <= 1'b0;
      r_lo      <= '0;
      r_ovf     <= 1'b0;
      r_vblank  <= 1'b0;
      r_nmi     <= 1'b1;
      r_rgb     <= '0;
      r_hs      <= '0;
      r_vs      <= '0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_vpos_d1 <= '0;
      r_hsub_d1 <= '0;
      r_don_d1  <= 1'b0;
      r_grid_d1 <= 1'b0;
    end else begin
      if (w_wr_data) begin
        r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
        if (w_full) r_ovf <= 1'b1;
      end
      if (w_enq)     r_wp   <= r_wp + 1'b1;
      if (w_drain)   r_rp   <= r_rp + 1'b1;
      if (w_wr_attr) r_attr <= cpu_data[5:0];
      if (w_wr_ctrl) begin
        r_ctrl <= cpu_data;
        r_ovf  <= 1'b0;
        r_tog  <= 1'b0;
      end
      if (w_wr_addr) begin
        r_tog <= ~r_tog;
        if (!r_tog) r_lo  <= cpu_data;
        else        r_ptr <= (w_newptr >= CELLS_16) ? '0 : AW'(w_newptr);
      end
      r_vblank  <= w_vb_nxt;
      r_nmi     <= ~(w_vb_nxt && w_ctrl_nxt[6]);
      r_vpos_d1 <= vpos;
      r_hsub_d1 <= hpos[S+2:S];
      r_don_d1  <= display_on;
      r_grid_d1 <= w_in_grid;
      r_hs      <= {r_hs[0], hsync_in};
      r_vs      <= {r_vs[0], vsync_in};
      r_rgb     <= (r_don_d1 && r_ctrl[7] && r_grid_d1) ? w_pix : 3'd0;
    end
  end

  assign status     = {r_vblank, w_full, r_ovf, w_empty, 4'b0};
  assign glyph_code = r_cell[13:6];
  assign glyph_row  = r_vpos_d1[S+2:S];
  assign hsync      = r_hs[1];
  assign vsync      = r_vs[1];
  assign nmi        = r_nmi;
  assign rgb        = r_rgb;
  assign w_unused   = ^{r_ctrl[5:0], hpos};
endmodule

// File: tb/tb_vdp_text_engine.sv
// Scoreboard bench for vdp_text_engine: stimulus queues timed expectations, a negedge monitor checks them.
// Glyph ROM model: glyph_bits = glyph_code ^ {glyph_row, 5'b0}; rgb expected 2 clks after hpos/vpos.
// No backpressure: cpu writes are single-clk strobes, FIFO overflow observed via status.
module tb_vdp_text_engine;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] hpos = '0, vpos = '0;
  logic       display_on = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic       cpu_we = 1'b0;
  logic [1:0] cpu_addr = '0;
  logic [7:0] cpu_data = '0;
  logic [7:0] status, glyph_code, glyph_bits;
  logic [2:0] glyph_row, rgb;
  logic       hsync, vsync, nmi;

  localparam int RGB = 0, ST = 1, NMI = 2, HS = 3, VS = 4, GCODE = 5, GROW = 6;

  typedef struct {
    int         cyc;
    int         sig;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  vdp_text_engine dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .status(status), .glyph_code(glyph_code), .glyph_row(glyph_row),
    .glyph_bits(glyph_bits), .hsync(hsync), .vsync(vsync), .nmi(nmi), .rgb(rgb)
  );

  assign glyph_bits = glyph_code ^ {glyph_row, 5'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string nm(input int s);
    case (s)
      RGB: return "rgb";
      ST: return "status";
      NMI: return "nmi";
      HS: return "hsync";
      VS: return "vsync";
      GCODE: return "glyph_code";
      default: return "glyph_row";
    endcase
  endfunction

  function automatic logic [7:0] sample(input int s);
    case (s)
      RGB: return {5'b0, rgb};
      ST: return status;
      NMI: return {7'b0, nmi};
      HS: return {7'b0, hsync};
      VS: return {7'b0, vsync};
      GCODE: return glyph_code;
      default: return {5'b0, glyph_row};
    endcase
  endfunction

  // monitor: pops every expectation due this cycle
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        logic [7:0] act;
        act = sample(sb[i].sig);
        checks++;
        if (sb[i].cyc != cyc || act !== sb[i].val) begin
          errors++;
          $display("FAIL %s @cyc %0d (due %0d): got %0h expected %0h",
                   nm(sb[i].sig), cyc, sb[i].cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int s, input logic [7:0] v, input int d);
    sb.push_back('{cyc + d, s, v});
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cpu_we = 1'b1; cpu_addr = a; cpu_data = d;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic render(input int h, input int v, input logic [2:0] e);
    hpos = 10'(h); vpos = 10'(v); display_on = 1'b1;
    expect_at(RGB, {5'b0, e}, 2);
    tick();
  endtask

  task automatic blank(input int n);
    display_on = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    expect_at(ST, 8'h10, 0); expect_at(NMI, 8'h01, 0);
    expect_at(RGB, 8'h00, 0); expect_at(HS, 8'h00, 0);
    checks++;
    if (status !== 8'h10) begin
      errors++;
      $display("FAIL status after reset: got %0h expected 10", status);
    end
    checks++;
    if (nmi !== 1'b1) begin
      errors++;
      $display("FAIL nmi after reset: got %0b expected 1", nmi);
    end
    checks++;
    if (rgb !== 3'd0) begin
      errors++;
      $display("FAIL rgb after reset: got %0h expected 0", rgb);
    end
    tick();

    // 'A' at cell 0, default attr bg0/fg7; display disabled first
    wr(0, 8'h41);
    blank(2);
    render(2, 0, 0);
    blank(1);
    wr(2, 8'h80);
    expect_at(GCODE, 8'h41, 1);
    render(0, 0, 0);
    render(2, 0, 7);
    render(14, 0, 7);
    expect_at(GROW, 8'h01, 1);
    render(4, 2, 7);
    render(0, 2, 0);
    render(2, 2, 7);
    render(700, 0, 0);
    blank(2);
    hsync_in = 1'b1; vsync_in = 1'b1;
    expect_at(HS, 8'h01, 2); expect_at(HS, 8'h00, 3); expect_at(VS, 8'h01, 2);
    tick();
    hsync_in = 1'b0; vsync_in = 1'b0;
    tick();

    // pointer 1199 wraps to 0
    wr(3, 8'hAF); wr(3, 8'h04);
    wr(1, 8'h15);
    wr(0, 8'h42); wr(0, 8'h42);
    blank(4);
    render(624, 464, 2);
    render(626, 464, 5);
    render(0, 0, 2);
    render(2, 0, 5);
    blank(1);
    wr(1, 8'h05); wr(0, 8'hFF);
    blank(3);
    render(16, 0, 5);
    render(18, 2, 5);
    render(20, 2, 0);

    // overflow during active video, then drain in blanking
    blank(1);
    wr(3, 8'h64); wr(3, 8'h00); wr(1, 8'h03);
    hpos = '0; vpos = '0; display_on = 1'b1;
    for (int i = 0; i < 8; i++) wr(0, 8'hFF);
    expect_at(ST, 8'h40, 0);
    wr(0, 8'hFF);
    expect_at(ST, 8'h60, 0);
    blank(4);
    expect_at(ST, 8'h20, 0);
    blank(4);
    expect_at(ST, 8'h30, 0);
    wr(2, 8'h80);
    expect_at(ST, 8'h10, 0);
    render(320, 32, 3);
    render(432, 32, 3);
    blank(2);

    // vblank / nmi
    vpos = 10'd0;
    wr(2, 8'hC0);
    vpos = 10'd481; tick();
    expect_at(NMI, 8'h01, 0);
    vpos = 10'd482; tick();
    expect_at(NMI, 8'h00, 0); expect_at(ST, 8'h90, 0);
    checks++;
    if (nmi !== 1'b0) begin
      errors++;
      $display("FAIL nmi at vblank: got %0b expected 0", nmi);
    end
    checks++;
    if (status !== 8'h90) begin
      errors++;
      $display("FAIL status at vblank: got %0h expected 90", status);
    end
    tick();
    expect_at(NMI, 8'h00, 0);
    wr(2, 8'hC0);
    expect_at(NMI, 8'h01, 0); expect_at(ST, 8'h10, 0);
    tick();
    expect_at(ST, 8'h10, 0);
    vpos = 10'd0; tick();
    vpos = 10'd482; tick();
    expect_at(ST, 8'h90, 0);
    vpos = 10'd0; tick();
    expect_at(ST, 8'h10, 0); expect_at(NMI, 8'h01, 0);

    // out-of-range address loads 0
    wr(3, 8'hFF); wr(3, 8'hFF);
    wr(1, 8'h38); wr(2, 8'h80); wr(0, 8'h00);
    blank(3);
    render(0, 0, 7);
    render(2, 0, 7);
    render(16, 0, 5);

    // reset mid-drain
    display_on = 1'b1;
    for (int i = 0; i < 4; i++) wr(0, 8'h00);
    blank(1);
    reset = 1'b1;
    tick();
    expect_at(ST, 8'h10, 0); expect_at(NMI, 8'h01, 0);
    checks++;
    if (status !== 8'h10) begin
      errors++;
      $display("FAIL status after mid-drain reset: got %0h expected 10", status);
    end
    checks++;
    if (nmi !== 1'b1) begin
      errors++;
      $display("FAIL nmi after mid-drain reset: got %0b expected 1", nmi);
    end
    reset = 1'b0;
    tick();
    expect_at(ST, 8'h10, 0); expect_at(RGB, 8'h00, 0);

`ifdef CURSOR_EN
    wr(2, 8'hA0);
    render(0, 0, 7);
    render(16, 0, 7);
    blank(1);
    for (int i = 0; i < 16; i++) begin
      vpos = 10'd482; tick();
      vpos = 10'd0; tick();
    end
    render(0, 0, 0);
    render(16, 0, 7);
`else
    wr(2, 8'hA0);
    render(0, 0, 7);
    render(16, 0, 7);
`endif
    blank(4);

    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s expired: due cyc %0d, expected %0h", nm(sb[i].sig), sb[i].cyc, sb[i].val);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
